// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG MCU sequencer and its code mux.
package jpeg_pkg;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_GAP,
      ST_DCT,
      ST_DCT_END,
      ST_ZZ_LOAD,
      ST_ZZ,
      ST_HUFF,
      ST_DRAIN
   } seq_state_t;

   localparam int BLK_PIX  = 64;
   localparam int ROWS     = 8;
   localparam int CTRL_LAT = 20;

   localparam int CH_Y  = 0;
   localparam int CH_CB = 1;
   localparam int CH_CR = 2;

   // Saturating increment used by the optional block-cycle counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/jpeg_code_mux.sv
// Selects one encoder channel's code stream onto the merged output while the
// sequencer drains; every output is idle (zero) when not active.
module jpeg_code_mux
   import jpeg_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int CODE_W = 16,
   parameter int LEN_W  = 8
) (
   input  logic                     active,
   input  logic [1:0]               sel,
   input  logic [NUM_CH-1:0]        code_valid,
   input  logic [NUM_CH*CODE_W-1:0] code,
   input  logic [NUM_CH*LEN_W-1:0]  code_len,
   input  logic [NUM_CH-1:0]        block_done,
   input  logic                     m_ready,
   output logic [NUM_CH-1:0]        code_ready,
   output logic                     m_valid,
   output logic [CODE_W-1:0]        m_code,
   output logic [LEN_W-1:0]         m_len,
   output logic [1:0]               m_ch,
   output logic                     sel_done
);

   always_comb begin
      // NOTE: every output is assigned a default first, so no path through the loop can infer a latch.
      code_ready = '0;
      m_valid    = 1'b0;
      m_code     = '0;
      m_len      = '0;
      m_ch       = '0;
      sel_done   = 1'b0;
      if (active) begin
         m_ch = sel;
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == 2'(i)) begin
               m_valid       = code_valid[i];
               m_code        = code[i*CODE_W +: CODE_W];
               m_len         = code_len[i*LEN_W +: LEN_W];
               sel_done      = block_done[i];
               code_ready[i] = m_ready;
            end
         end
      end
   end

endmodule

// File: rtl/jpeg_mcu_sequencer.sv
// Per-block phase sequencer and Huffman code collector for the JPEG encoder.
// Optional macro JPEG_SEQ_PERF_EN adds the blk_cycles block-latency output.
module jpeg_mcu_sequencer
   import jpeg_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int PIX_W  = 10,
   parameter int CODE_W = 16,
   parameter int LEN_W  = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [NUM_CH*PIX_W-1:0]  s_pix,
   output logic                     enc_pix_valid,
   output logic [NUM_CH*PIX_W-1:0]  enc_pix,
   output logic                     enc_dct_en,
   output logic                     enc_dct_end,
   output logic                     enc_zz_load,
   output logic                     enc_zz_en,
   output logic [7:0]               enc_row,
   output logic                     enc_huff_start,
   input  logic [NUM_CH-1:0]        enc_code_valid,
   input  logic [NUM_CH*CODE_W-1:0] enc_code,
   input  logic [NUM_CH*LEN_W-1:0]  enc_code_len,
   input  logic [NUM_CH-1:0]        enc_block_done,
   output logic [NUM_CH-1:0]        enc_code_ready,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [CODE_W-1:0]        m_code,
   output logic [LEN_W-1:0]         m_len,
   output logic [1:0]               m_ch,
   output logic                     m_blk_end,
   output logic [15:0]              blk_count
`ifdef JPEG_SEQ_PERF_EN
   ,
   output logic [15:0]              blk_cycles
`endif
);

   localparam logic [1:0] LAST_SEL = 2'(NUM_CH - 1);

   seq_state_t  state;
   seq_state_t  state_next;
   logic [5:0]  pix_cnt;
   logic [2:0]  row_cnt;
   logic [1:0]  sel;
   logic        pix_accept;
   logic        row_last;
   logic        sweeping;
   logic        drain_active;
   logic        sel_done;

   assign pix_accept   = s_valid && s_ready;
   assign row_last     = (row_cnt == 3'(ROWS - 1));
   assign sweeping     = (state == ST_DCT) || (state == ST_ZZ);
   assign drain_active = (state == ST_DRAIN);
   assign m_blk_end    = drain_active && sel_done && (sel == LAST_SEL);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_LOAD:    if (pix_accept && (pix_cnt == 6'(BLK_PIX - 1))) state_next = ST_GAP;
         ST_GAP:     state_next = ST_DCT;
         ST_DCT:     if (row_last) state_next = ST_DCT_END;
         ST_DCT_END: state_next = ST_ZZ_LOAD;
         ST_ZZ_LOAD: state_next = ST_ZZ;
         ST_ZZ:      if (row_last) state_next = ST_HUFF;
         ST_HUFF:    state_next = ST_DRAIN;
         ST_DRAIN:   if (m_blk_end) state_next = ST_LOAD;
         default:    state_next = ST_LOAD;
      endcase
   end

   always_comb begin
      s_ready        = 1'b0;
      enc_dct_en     = 1'b0;
      enc_dct_end    = 1'b0;
      enc_zz_load    = 1'b0;
      enc_zz_en      = 1'b0;
      enc_huff_start = 1'b0;
      enc_row        = '0;
      unique case (state)
         ST_LOAD:    s_ready = 1'b1;
         ST_DCT: begin
            enc_dct_en = 1'b1;
            enc_row    = {5'd0, row_cnt};
         end
         ST_DCT_END: enc_dct_end = 1'b1;
         ST_ZZ_LOAD: enc_zz_load = 1'b1;
         ST_ZZ: begin
            enc_zz_en = 1'b1;
            enc_row   = {5'd0, row_cnt};
         end
         ST_HUFF:    enc_huff_start = 1'b1;
         default:    ;
      endcase
   end

   // Row counter runs only inside a sweep and wraps 7 -> 0 as the sweep ends.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enc_pix_valid <= 1'b0;
         enc_pix       <= '0;
         pix_cnt       <= '0;
         row_cnt       <= '0;
         sel           <= '0;
         blk_count     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         enc_pix_valid <= pix_accept;
         if (pix_accept) begin
            enc_pix <= s_pix;
            pix_cnt <= pix_cnt + 6'd1;
         end
         row_cnt <= sweeping ? row_cnt + 3'd1 : 3'd0;
         if (drain_active && sel_done) begin
            sel <= (sel == LAST_SEL) ? 2'd0 : sel + 2'd1;
         end
         if (m_blk_end) begin
            blk_count <= blk_count + 16'd1;
         end
      end
   end

   jpeg_code_mux #(
      .NUM_CH (NUM_CH),
      .CODE_W (CODE_W),
      .LEN_W  (LEN_W)
   ) u_code_mux (
      .active     (drain_active),
      .sel        (sel),
      .code_valid (enc_code_valid),
      .code       (enc_code),
      .code_len   (enc_code_len),
      .block_done (enc_block_done),
      .m_ready    (m_ready),
      .code_ready (enc_code_ready),
      .m_valid    (m_valid),
      .m_code     (m_code),
      .m_len      (m_len),
      .m_ch       (m_ch),
      .sel_done   (sel_done)
   );

`ifdef JPEG_SEQ_PERF_EN
   // A block is open from its first pixel accept until the FSM is back in LOAD with pix_cnt=0.
   logic [15:0] cyc_cnt;
   logic        blk_open;

   assign blk_open = !((state == ST_LOAD) && (pix_cnt == 6'd0));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cyc_cnt    <= '0;
         blk_cycles <= '0;
      end else begin
         if (pix_accept && (pix_cnt == 6'd0)) begin
            cyc_cnt <= 16'd1;
         end else if (blk_open) begin
            cyc_cnt <= sat_inc16(cyc_cnt);
         end
         if (m_blk_end) begin
            blk_cycles <= sat_inc16(cyc_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_jpeg_mcu_sequencer.sv
// Scoreboard bench for jpeg_mcu_sequencer: pixel echo, phase timing, drain order, reset.
module tb_jpeg_mcu_sequencer;
   import jpeg_pkg::*;

   localparam int NUM_CH = 3;
   localparam int PIX_W  = 10;
   localparam int CODE_W = 16;
   localparam int LEN_W  = 8;
   localparam int ENT_W  = 2 + LEN_W + CODE_W;

   logic                     clock;
   logic                     reset_n;
   logic                     s_valid;
   logic                     s_ready;
   logic [NUM_CH*PIX_W-1:0]  s_pix;
   logic                     enc_pix_valid;
   logic [NUM_CH*PIX_W-1:0]  enc_pix;
   logic                     enc_dct_en;
   logic                     enc_dct_end;
   logic                     enc_zz_load;
   logic                     enc_zz_en;
   logic [7:0]               enc_row;
   logic                     enc_huff_start;
   logic [NUM_CH-1:0]        enc_code_valid;
   logic [NUM_CH*CODE_W-1:0] enc_code;
   logic [NUM_CH*LEN_W-1:0]  enc_code_len;
   logic [NUM_CH-1:0]        enc_block_done;
   logic [NUM_CH-1:0]        enc_code_ready;
   logic                     m_valid;
   logic                     m_ready;
   logic [CODE_W-1:0]        m_code;
   logic [LEN_W-1:0]         m_len;
   logic [1:0]               m_ch;
   logic                     m_blk_end;
   logic [15:0]              blk_count;
`ifdef JPEG_SEQ_PERF_EN
   logic [15:0]              blk_cycles;
`endif

   jpeg_mcu_sequencer #(
      .NUM_CH (NUM_CH),
      .PIX_W  (PIX_W),
      .CODE_W (CODE_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_pix          (s_pix),
      .enc_pix_valid  (enc_pix_valid),
      .enc_pix        (enc_pix),
      .enc_dct_en     (enc_dct_en),
      .enc_dct_end    (enc_dct_end),
      .enc_zz_load    (enc_zz_load),
      .enc_zz_en      (enc_zz_en),
      .enc_row        (enc_row),
      .enc_huff_start (enc_huff_start),
      .enc_code_valid (enc_code_valid),
      .enc_code       (enc_code),
      .enc_code_len   (enc_code_len),
      .enc_block_done (enc_block_done),
      .enc_code_ready (enc_code_ready),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_code         (m_code),
      .m_len          (m_len),
      .m_ch           (m_ch),
      .m_blk_end      (m_blk_end),
      .blk_count      (blk_count)
`ifdef JPEG_SEQ_PERF_EN
      ,
      .blk_cycles     (blk_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   int cyc         = 0;
   int acc_cnt     = 0;
   int first_acc   = 0;
   int last_t      = -1000;
   int blk_end_cnt = 0;
   int end_cyc     = 0;
   int codes_out   = 0;
   int blk_salt    = 0;
   bit in_drain    = 1'b0;
   bit prev_end    = 1'b0;
   bit rnd_ready   = 1'b0;

   logic [NUM_CH*PIX_W-1:0] pix_q[$];
   logic [ENT_W-1:0]        exp_q[$];

   // Encoder models: per-channel code FIFOs plus done request/coincide flags.
   logic [CODE_W+LEN_W-1:0] code_mem[NUM_CH][16];
   int                      head[NUM_CH];
   int                      tail[NUM_CH];
   logic [NUM_CH-1:0]       done_req;
   logic [NUM_CH-1:0]       coincide;
   logic [NUM_CH-1:0]       fire;
   logic [NUM_CH-1:0]       take;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Expected {dct_en, dct_end, zz_load, zz_en, huff_start, row} k cycles after the 64th accept.
   function automatic logic [12:0] phase_exp(input int k);
      logic       de   = 1'b0;
      logic       dend = 1'b0;
      logic       zl   = 1'b0;
      logic       ze   = 1'b0;
      logic       hs   = 1'b0;
      logic [7:0] r    = 8'd0;
      if (k >= 2 && k < 2 + ROWS) begin
         de = 1'b1;
         r  = 8'(k - 2);
      end
      if (k == 2 + ROWS) dend = 1'b1;
      if (k == 3 + ROWS) zl = 1'b1;
      if (k >= 4 + ROWS && k < 4 + 2*ROWS) begin
         ze = 1'b1;
         r  = 8'(k - 4 - ROWS);
      end
      if (k == CTRL_LAT) hs = 1'b1;
      return {de, dend, zl, ze, hs, r};
   endfunction

   task automatic drive_enc();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int n;
         n = tail[ch] - head[ch];
         enc_code_valid[ch] = (n > 0);
         if (n > 0) begin
            {enc_code[ch*CODE_W +: CODE_W], enc_code_len[ch*LEN_W +: LEN_W]} = code_mem[ch][head[ch]];
         end else begin
            {enc_code[ch*CODE_W +: CODE_W], enc_code_len[ch*LEN_W +: LEN_W]} = '0;
         end
         enc_block_done[ch] = done_req[ch] && ((n == 0) || (coincide[ch] && n == 1));
      end
   endtask

   task automatic load_codes(input int n0, input int n1, input int n2, input logic [NUM_CH-1:0] coin);
      int n[3];
      logic [CODE_W-1:0] code;
      logic [LEN_W-1:0]  len;
      n = '{n0, n1, n2};
      blk_salt++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         head[ch] = 0;
         tail[ch] = 0;
         for (int i = 0; i < n[ch]; i++) begin
            code = CODE_W'(16'hC000 + ch*256 + blk_salt*16 + i);
            len  = LEN_W'(ch*16 + i + 1);
            code_mem[ch][i] = {code, len};
            tail[ch]++;
            exp_q.push_back({2'(ch), len, code});
         end
      end
      done_req = '1;
      coincide = coin;
      drive_enc();
   endtask

   task automatic clear_model();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         head[ch] = 0;
         tail[ch] = 0;
      end
      done_req = '0;
      coincide = '0;
      exp_q.delete();
      drive_enc();
   endtask

   task automatic check_reset();
      check("rst_ctl", {s_ready, enc_pix_valid, enc_dct_en, enc_dct_end, enc_zz_load, enc_zz_en,
                        enc_huff_start, m_valid, m_blk_end}, 9'b1_0000_0000);
      check("rst_pix", enc_pix, 0);
      check("rst_row", enc_row, 0);
      check("rst_mout", {m_code, m_len, m_ch}, 0);
      check("rst_blk_count", blk_count, 0);
      check("rst_code_ready", enc_code_ready, 0);
`ifdef JPEG_SEQ_PERF_EN
      check("rst_blk_cycles", blk_cycles, 0);
`endif
   endtask

   // Bounded wait for s_ready; returns at negedge+1 with the accept pending on the next edge.
   task automatic wait_ready();
      int g = 0;
      do begin
         @(negedge clock);
         #1;
         g++;
      end while (!s_ready && g < 300);
      if (!s_ready) check("ready_timeout", s_ready, 1);
   endtask

   task automatic send_pixels(input int b0, input int n, input bit toggle);
      for (int b = b0; b < b0 + n; b++) begin
         s_valid = 1'b1;
         s_pix   = {NUM_CH{PIX_W'(b)}};
         wait_ready();
         @(posedge clock);
         #1;
         if (toggle) begin
            s_valid = 1'b0;
            @(posedge clock);
            #1;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_blk_end(input int e0);
      int g = 0;
      while (blk_end_cnt == e0 && g < 600) begin
         @(negedge clock);
         #1;
         g++;
      end
      check("blk_end_seen", blk_end_cnt - e0, 1);
   endtask

   always @(negedge clock) begin : monitor
      logic [NUM_CH-1:0] unsel;
      int k;
      cyc++;
      if (!reset_n) begin
         acc_cnt  = 0;
         pix_q.delete();
         last_t   = -1000;
         in_drain = 1'b0;
         prev_end = 1'b0;
         fire     = '0;
         take     = '0;
      end else begin
         if (enc_pix_valid) begin
            check("pix_pending", pix_q.size() != 0, 1);
            if (pix_q.size() != 0) check("enc_pix", enc_pix, pix_q.pop_front());
         end
         if (s_valid && s_ready) begin
            pix_q.push_back(s_pix);
            if (acc_cnt == 0) first_acc = cyc;
            acc_cnt++;
            if (acc_cnt == BLK_PIX) begin
               last_t  = cyc;
               acc_cnt = 0;
            end
         end
         k = cyc - last_t;
         check("strobes", {enc_dct_en, enc_dct_end, enc_zz_load, enc_zz_en, enc_huff_start, enc_row},
               phase_exp(k));
         if (k >= 1 && k <= CTRL_LAT) check("s_ready_seq", s_ready, 0);
         if (in_drain) check("s_ready_drain", s_ready, 0);
         if (prev_end) check("s_ready_resume", s_ready, 1);

         if (m_valid && m_ready) begin
            codes_out++;
            check("code_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("m_code", {m_ch, m_len, m_code}, exp_q.pop_front());
         end
         unsel = in_drain ? ~(NUM_CH'(1) << m_ch) : '1;
         check("rdy_unsel", enc_code_ready & unsel, 0);
         if (in_drain) check("rdy_sel", enc_code_ready[m_ch], m_ready);

         fire = enc_code_valid & enc_code_ready;
         take = '0;
         if (in_drain) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               if (enc_block_done[ch] && m_ch == 2'(ch)) take[ch] = 1'b1;
            end
         end
         if (m_blk_end) begin
            blk_end_cnt++;
            end_cyc = cyc;
            check("blk_end_drained", exp_q.size(), 0);
            in_drain = 1'b0;
         end
         prev_end = m_blk_end;
         if (enc_huff_start) in_drain = 1'b1;
      end
   end

   // Encoder-side handshake: apply what transferred on the edge, then present new values.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (fire[ch] && head[ch] < tail[ch]) head[ch]++;
            if (take[ch]) done_req[ch] = 1'b0;
         end
         fire = '0;
         take = '0;
         drive_enc();
         m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      int c0;
      int acc_cyc;
      int span;
      reset_n = 1'b0;
      s_valid = 1'b0;
      s_pix   = '0;
      m_ready = 1'b1;
      fire    = '0;
      take    = '0;
      clear_model();

      repeat (3) @(negedge clock);
      #1;
      check_reset();
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Block A: unstalled pixels, 3/5/2 codes, random m_ready.
      rnd_ready = 1'b1;
      load_codes(3, 5, 2, 3'b000);
      e0 = blk_end_cnt;
      c0 = codes_out;
      send_pixels(0, BLK_PIX, 1'b0);
      check("load_span_a", last_t - first_acc + 1, BLK_PIX);
      wait_blk_end(e0);
      check("codes_a", codes_out - c0, 10);
      @(negedge clock);
      #1;
      check("blk_count_a", blk_count, 1);
      @(posedge clock);
      #1;

      // Block B: s_valid every other cycle, ch1 done raised early, 65th beat held.
      rnd_ready = 1'b0;
      load_codes(4, 1, 2, 3'b010);
      e0 = blk_end_cnt;
      c0 = codes_out;
      send_pixels(0, BLK_PIX, 1'b1);
      check("load_span_b", last_t - first_acc + 1, 2*BLK_PIX - 1);
      s_valid = 1'b1;
      s_pix   = {NUM_CH{PIX_W'(BLK_PIX)}};
      wait_ready();
      acc_cyc = cyc;
      @(posedge clock);
      #1;
      s_valid = 1'b0;
      check("held_until_end", blk_end_cnt - e0, 1);
      check("resume_gap", acc_cyc - end_cyc, 1);
      check("codes_b", codes_out - c0, 7);
      check("blk_count_b", blk_count, 2);

      // Block C: finish the block, then reset during ZZ row 4.
      send_pixels(1, BLK_PIX - 1, 1'b0);
      begin
         int g = 0;
         do begin
            @(negedge clock);
            #1;
            g++;
         end while (!(enc_zz_en && enc_row == 8'd4) && g < 100);
         check("reach_zz_row4", {enc_zz_en, enc_row}, {1'b1, 8'd4});
      end
      reset_n = 1'b0;
      #1;
      check_reset();
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      #1;
      check_reset();
      clear_model();
      @(posedge clock);
      #1;

      // Block D: fresh block after reset, unstalled, codes coincide with done.
      load_codes(3, 5, 2, 3'b111);
      e0 = blk_end_cnt;
      c0 = codes_out;
      send_pixels(0, BLK_PIX, 1'b0);
      check("load_span_d", last_t - first_acc + 1, BLK_PIX);
      wait_blk_end(e0);
      span = end_cyc - first_acc + 1;
      check("codes_d", codes_out - c0, 10);
      check("blk_span_d", span, 94);
      @(negedge clock);
      #1;
      check("blk_count_d", blk_count, 1);
`ifdef JPEG_SEQ_PERF_EN
      check("blk_cycles_d", blk_cycles, span);
`endif
      repeat (3) @(negedge clock);
      check("blk_end_once", blk_end_cnt - e0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jpeg_mcu_sequencer.md
# jpeg_mcu_sequencer

Parametrised control-and-collection block for the JPEG encoder data path. It accepts colour-converted pixels for NUM_CH component channels, 64 per 8x8 block, as a valid/ready stream. It generates every per-block phase strobe the per-channel encoders need internally: pixel load, DCT row sweep, DCT end, zigzag load/sweep and Huffman start. It then drains each channel's Huffman codes, in channel order, onto a single code stream, replacing the externally driven strobes used by the current encoder top.

## Interface
- NUM_CH, 3, number of component channels (Y, Cb, Cr order), 1..4
- PIX_W, 10, signed pixel width per channel
- CODE_W, 16, Huffman code width
- LEN_W, 8, code-length field width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  pixel beat valid
- s_ready  out  1  pixel beat accepted when s_valid & s_ready
- s_pix  in  NUM_CH*PIX_W  one pixel per channel, channel 0 in LSBs
- enc_pix_valid  out  1  registered pixel strobe to all encoders
- enc_pix  out  NUM_CH*PIX_W  registered copy of the accepted s_pix
- enc_dct_en  out  1  DCT row-sweep enable
- enc_dct_end  out  1  single-cycle DCT end pulse
- enc_zz_load  out  1  single-cycle zigzag load pulse
- enc_zz_en  out  1  zigzag sweep enable
- enc_row  out  8  current row index 0..7 during DCT/ZZ sweeps, else 0
- enc_huff_start  out  1  single-cycle Huffman start pulse
- enc_code_valid  in  NUM_CH  per-channel code valid
- enc_code  in  NUM_CH*CODE_W  per-channel code
- enc_code_len  in  NUM_CH*LEN_W  per-channel code length
- enc_block_done  in  NUM_CH  per-channel end-of-block pulse
- enc_code_ready  out  NUM_CH  per-channel backpressure
- m_valid / m_ready  out / in  1 / 1  merged code handshake
- m_code  out  CODE_W  selected code
- m_len  out  LEN_W  selected length
- m_ch  out  2  channel index of m_code
- m_blk_end  out  1  pulse when the last channel's block_done is taken
- blk_count  out  16  completed blocks, wraps at 65535 to 0

## Operation
- States: LOAD, GAP, DCT, DCT_END, ZZ_LOAD, ZZ, HUFF, DRAIN. Reset state is LOAD.
- LOAD: s_ready=1. Each transfer registers s_pix into enc_pix and asserts enc_pix_valid on the next cycle. pix_cnt (6 bit) increments. The 64th transfer (pix_cnt=63) moves the FSM to GAP.
- GAP: 1 cycle, s_ready=0. It lets the final enc_pix_valid land before DCT starts.
- DCT: 8 cycles, enc_dct_en=1, enc_row=0..7. Then DCT_END for 1 cycle, then ZZ_LOAD for 1 cycle.
- ZZ: 8 cycles, enc_zz_en=1, enc_row=0..7. Then HUFF for 1 cycle (enc_huff_start=1).
- DRAIN: sel starts at 0.
  - m_valid=enc_code_valid[sel]; m_code, m_len and m_ch are muxed from sel.
  - enc_code_ready[sel]=m_ready. Unselected channels' ready=0.
  - enc_block_done[sel] advances sel; it may coincide with a code transfer, and that transfer completes.
  - A done on sel=NUM_CH-1 pulses m_blk_end, increments blk_count, and returns the FSM to LOAD.
- enc_block_done on an unselected channel is ignored. Encoders hold their done until selected.
- Phase strobes never overlap. s_ready=0 in every state except LOAD.

## Timing
- Reset values:
  - s_ready=1.
  - enc_pix_valid, enc_dct_en, enc_dct_end, enc_zz_load, enc_zz_en, enc_huff_start, m_valid, m_blk_end = 0.
  - enc_pix, enc_row, m_code, m_len, m_ch, blk_count = 0; enc_code_ready=0.
- Fixed control latency: 64th accept at cycle T → GAP T+1 → first enc_dct_en T+2 → enc_dct_end T+10 → enc_zz_load T+11 → first enc_zz_en T+12 → enc_huff_start T+20 → DRAIN T+21.
- Back-to-back blocks: the first s_ready of the next block comes the cycle after m_blk_end.
- m_code, m_len and m_ch are combinational from registered sel and encoder outputs. m_valid may not depend on m_ready.
- Reset mid-block (any state) returns the FSM to LOAD, clears pix_cnt, sel and the row counter, and discards the partial block.

## Configuration
- JPEG_SEQ_PERF_EN defined:
  - Adds output blk_cycles (16 bit): cycles from the first pixel accept of a block to its m_blk_end, inclusive, saturating at 65535.
  - blk_cycles is updated on m_blk_end and reset to 0.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package jpeg_pkg holds:
  - the state enum;
  - the constants BLK_PIX=64, ROWS=8 and the control latency 20;
  - the channel index constants CH_Y=0, CH_CB=1, CH_CR=2.
- One sub-module, jpeg_code_mux: the sel-indexed valid/ready/code/len mux, parametrised by NUM_CH, CODE_W and LEN_W.

## Test plan
- 64 beats with s_pix channel values = beat index, no stalls:
  - enc_pix_valid fires 64 times, with enc_pix matching one cycle later.
  - enc_dct_en lasts 8 cycles with rows 0..7, starting 2 cycles after the last accept.
  - enc_huff_start fires at T+20.
- s_valid toggled every other cycle: 64 accepts in 127 cycles; a 65th beat is held (s_ready=0) until m_blk_end.
- DRAIN with the encode models emitting 3/5/2 codes on ch0/1/2 and m_ready random at 50%:
  - 10 codes emerge in channel order, with m_ch=0,0,0,1,…,2.
  - m_blk_end fires once; blk_count=1.
- Ch1 raises enc_block_done while sel=0: it is ignored until sel=1, ch1 codes are held with ready=0, and no code is lost or reordered.
- reset_n asserted in ZZ at row 4, released: all outputs are at reset values; the next block starts at LOAD with pix_cnt=0.
- With JPEG_SEQ_PERF_EN and unstalled streams of 64 pixels + 10 codes, blk_cycles=64+1+18+1+10=94 (exact value checked by the model).
